// File: rtl/ring_counter_pkg.sv
// ============================================================================
// Module      : ring_counter_pkg
// Description : Shared defaults and rotation-direction encoding for the
//               single-hot ring counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ring_counter_pkg;

    localparam int                       DEFAULT_WIDTH = 4;
    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_SEED  = 4'b0001;

    // Rotation direction: left moves the hot bit toward the MSB.
    localparam bit DIR_LEFT  = 1'b0;
    localparam bit DIR_RIGHT = 1'b1;

endpackage : ring_counter_pkg

`default_nettype wire

// File: rtl/ring_counter_onehot_check.sv
// ============================================================================
// Module      : onehot_check
// Description : Combinational one-hot detector; o_valid is high iff exactly
//               one bit of i_data is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_check #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid
);

    logic w_any;
    logic w_multi;

    // Track "seen a one" and "seen a second one" in a single scan.
    always_comb begin
        w_any   = 1'b0;
        w_multi = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_multi = w_multi | (w_any & i_data[i]);
            w_any   = w_any | i_data[i];
        end
    end

    assign o_valid = w_any & ~w_multi;

endmodule : onehot_check

`default_nettype wire

// File: rtl/ring_counter.sv
// ============================================================================
// Module      : ring_counter
// Description : Free-running single-hot ring counter with self-recovery from
//               any non-one-hot state back to SEED.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_counter
    import ring_counter_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED),
    parameter bit               DIR   = DIR_LEFT
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] data_out
);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("ring_counter: WIDTH must be at least 2");
        end
        if (!$onehot(SEED)) begin : g_bad_seed
            $error("ring_counter: SEED must be one-hot");
        end
    endgenerate

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_rotated;
    logic [WIDTH-1:0] w_next;
    logic             w_state_valid;

    generate
        if (DIR == DIR_LEFT) begin : g_rot_left
            assign w_rotated = {r_state[WIDTH-2:0], r_state[WIDTH-1]};
        end else begin : g_rot_right
            assign w_rotated = {r_state[0], r_state[WIDTH-1:1]};
        end
    endgenerate

    onehot_check #(
        .WIDTH (WIDTH)
    ) u_onehot_check (
        .i_data  (r_state),
        .o_valid (w_state_valid)
    );

    // An illegal state is replaced by SEED on the next edge instead of rotating.
    assign w_next = w_state_valid ? w_rotated : SEED;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SEED;
        end else begin
            r_state <= w_next;
        end
    end

    assign data_out = r_state;

endmodule : ring_counter

`default_nettype wire

// File: tb/tb_ring_counter.sv
// ============================================================================
// Module      : tb_ring_counter
// Description : Directed self-checking bench for ring_counter (4-bit left,
//               4-bit right and 8-bit left instances on a shared reset).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_counter;
    import ring_counter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d_left;
    logic [3:0] d_right;
    logic [7:0] d_wide;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] exp_left  [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                  4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_right [8] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                  4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [7:0] exp_wide  [8] = '{8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h01};

    always #5 clk = ~clk;

    ring_counter #(.WIDTH(4), .SEED(4'b0001), .DIR(DIR_LEFT)) u_dut_l (
        .clk      (clk),
        .reset    (reset),
        .data_out (d_left)
    );

    ring_counter #(.WIDTH(4), .SEED(4'b0001), .DIR(DIR_RIGHT)) u_dut_r (
        .clk      (clk),
        .reset    (reset),
        .data_out (d_right)
    );

    ring_counter #(.WIDTH(8), .SEED(8'b0000_0001), .DIR(DIR_LEFT)) u_dut_w (
        .clk      (clk),
        .reset    (reset),
        .data_out (d_wide)
    );

    task automatic check_value(input string tag, input logic [7:0] actual,
                               input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, actual, expected, $time);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset asserted before any clock edge must show SEED immediately.
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check_value("reset_pre_edge_l", 8'(d_left),  8'h01);
        check_value("reset_pre_edge_r", 8'(d_right), 8'h01);
        check_value("reset_pre_edge_w", d_wide,      8'h01);

        repeat (2) begin
            @(negedge clk);
            check_value("reset_hold_l", 8'(d_left),  8'h01);
            check_value("reset_hold_r", 8'(d_right), 8'h01);
            check_value("reset_hold_w", d_wide,      8'h01);
        end

        // Release mid-cycle; the very next rising edge advances.
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_value("left_step",   8'(d_left),  8'(exp_left[k]));
            check_value("right_step",  8'(d_right), 8'(exp_right[k]));
            check_value("wide_step",   d_wide,      exp_wide[k]);
            check_value("wide_onehot", 8'($onehot(d_wide)), 8'h01);
        end

        @(negedge clk);
        check_value("left_pre_rst_a", 8'(d_left), 8'h02);
        @(negedge clk);
        check_value("left_pre_rst_b", 8'(d_left), 8'h04);

        // Reset asserted between edges overrides immediately.
        #2 reset = 1'b0;
        #1;
        check_value("midop_reset_l", 8'(d_left),  8'h01);
        check_value("midop_reset_r", 8'(d_right), 8'h01);
        @(negedge clk);
        check_value("midop_hold_l", 8'(d_left), 8'h01);
        reset = 1'b1;
        @(negedge clk);
        check_value("after_rst_l", 8'(d_left), 8'h02);

        // Illegal all-zero state recovers to SEED in one edge.
        force u_dut_l.r_state = 4'b0000;
        #1 release u_dut_l.r_state;
        check_value("forced_zero_l", 8'(d_left), 8'h00);
        @(negedge clk);
        check_value("recover_zero_l", 8'(d_left), 8'h01);
        @(negedge clk);
        check_value("resume_zero_l", 8'(d_left), 8'h02);

        // Illegal multi-hot state on both 4-bit instances.
        force u_dut_l.r_state = 4'b0110;
        force u_dut_r.r_state = 4'b1010;
        #1;
        release u_dut_l.r_state;
        release u_dut_r.r_state;
        check_value("forced_multi_l", 8'(d_left),  8'h06);
        check_value("forced_multi_r", 8'(d_right), 8'h0a);
        @(negedge clk);
        check_value("recover_multi_l", 8'(d_left),  8'h01);
        check_value("recover_multi_r", 8'(d_right), 8'h01);
        @(negedge clk);
        check_value("resume_multi_l", 8'(d_left),  8'h02);
        check_value("resume_multi_r", 8'(d_right), 8'h08);
        @(negedge clk);
        check_value("resume2_multi_l", 8'(d_left),  8'h04);
        check_value("resume2_multi_r", 8'(d_right), 8'h04);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ring_counter

`default_nettype wire
